fwd_hazard_unit: RTL and testbench

- Pipeline control block that produces the EX-stage forwarding selects (fwd_ctrl_a, fwd_ctrl_b) consumed by the ALU block.
- Consumes that block's branch-taken result (mux_sel_ctrl) and generates the PC/IF/ID hold, flush and bubble controls.
- Keeps its own shadow scoreboard of the instructions in EX and MEM, decoded from the IF/ID instruction word.
- Detects load-use hazards, resolves forwarding priority and counts stall/flush events.

---
 rtl/fwd_hazard_pkg.sv | 28 ++
 rtl/fwd_hazard_if.sv | 27 ++
 rtl/inst_dep_decode.sv | 65 ++++++
 rtl/fwd_hazard_unit.sv | 105 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_pkg.sv
// Shared opcode, forward-select and shadow-entry definitions for the
// forwarding / hazard control unit.
package fwd_hazard_pkg;

  localparam int SH_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [SH_AW-1:0] dst;
    logic             is_load;
  } shadow_t;

  localparam shadow_t SHADOW_NOP = '0;

endpackage

// File: rtl/fwd_hazard_if.sv
// Bus between the ID/EX pipeline and the forwarding / hazard control unit.
interface fwd_hazard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_id_inst;
  logic             branch_taken;
  logic [1:0]       fwd_ctrl_a;
  logic [1:0]       fwd_ctrl_b;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_inst, branch_taken,
    input  fwd_ctrl_a, fwd_ctrl_b, pc_write_en, if_id_write_en,
           if_id_flush, id_ex_bubble, stall_count, flush_count
  );

  modport slave (
    input  if_id_inst, branch_taken,
    output fwd_ctrl_a, fwd_ctrl_b, pc_write_en, if_id_write_en,
           if_id_flush, id_ex_bubble, stall_count, flush_count
  );
endinterface

// File: rtl/inst_dep_decode.sv
// Register-dependency decode of one instruction word: which registers it
// reads on each ALU operand, which it writes, and whether it is a load.
module inst_dep_decode
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst_i,
  output logic [REG_AW-1:0] src_a_o,
  output logic              use_a_o,
  output logic [REG_AW-1:0] src_b_o,
  output logic              use_b_o,
  output logic [REG_AW-1:0] dst_o,
  output logic              we_o,
  output logic              is_load_o
);

  logic [REG_AW-1:0] rs, rt, rd;
  logic              wr;
  logic              unused_imm_bits;

  assign rs = REG_AW'(inst_i[25:21]);
  assign rt = REG_AW'(inst_i[20:16]);
  assign rd = REG_AW'(inst_i[15:11]);
  // shamt/funct/immediate never affect register dependencies
  assign unused_imm_bits = ^inst_i[10:0];

  always_comb begin
    src_a_o   = rs;
    src_b_o   = rt;
    use_a_o   = 1'b0;
    use_b_o   = 1'b0;
    dst_o     = '0;
    wr        = 1'b0;
    is_load_o = 1'b0;
    case (inst_i[31:26])
      OP_RTYPE: begin
        use_a_o = 1'b1;
        use_b_o = 1'b1;
        dst_o   = rd;
        wr      = 1'b1;
      end
      OP_LW: begin
        use_a_o   = 1'b1;
        dst_o     = rt;
        wr        = 1'b1;
        is_load_o = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_a_o = 1'b1;
        use_b_o = 1'b1;
      end
      OP_ADDI: begin
        use_a_o = 1'b1;
        dst_o   = rt;
        wr      = 1'b1;
      end
      default: ;
    endcase
  end

  // $0 is hard-wired, so writing it never creates a dependency
  assign we_o = wr & (dst_o != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus load-use stall / taken-branch flush
// control, driven from a shadow scoreboard of the EX and MEM instructions.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);

  logic [REG_AW-1:0] dec_src_a, dec_src_b, dec_dst;
  logic              dec_use_a, dec_use_b, dec_we, dec_is_load;

  inst_dep_decode #(.REG_AW(REG_AW)) u_dec (
    .inst_i    (bus.if_id_inst),
    .src_a_o   (dec_src_a),
    .use_a_o   (dec_use_a),
    .src_b_o   (dec_src_b),
    .use_b_o   (dec_use_b),
    .dst_o     (dec_dst),
    .we_o      (dec_we),
    .is_load_o (dec_is_load)
  );

  shadow_t          ex_q, ex_d, mem_q;
  fwd_sel_e         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [SH_AW-1:0] sa, sb;
  logic             lu_a, lu_b, stall_raw, flush, stall_eff, hold;

  // A load's data is not on the EX/MEM path yet; only MEM/WB may carry it.
  function automatic logic fwd_hit(shadow_t s, logic [SH_AW-1:0] src,
                                   logic used, logic allow_load);
    return used & s.valid & s.we & (s.dst == src) & (allow_load | ~s.is_load);
  endfunction

  function automatic fwd_sel_e pick(logic ex_hit, logic mem_hit);
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_REG;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign sa = SH_AW'(dec_src_a);
  assign sb = SH_AW'(dec_src_b);

  assign lu_a      = dec_use_a & ex_q.valid & ex_q.we & ex_q.is_load & (ex_q.dst == sa);
  assign lu_b      = dec_use_b & ex_q.valid & ex_q.we & ex_q.is_load & (ex_q.dst == sb);
  assign stall_raw = lu_a | lu_b;
  assign flush     = bus.branch_taken;
  assign stall_eff = stall_raw & ~flush;
  assign hold      = stall_raw | flush;

  always_comb begin
    fwd_a_d = hold ? FWD_REG
                   : pick(fwd_hit(ex_q, sa, dec_use_a, 1'b0), fwd_hit(mem_q, sa, dec_use_a, 1'b1));
    fwd_b_d = hold ? FWD_REG
                   : pick(fwd_hit(ex_q, sb, dec_use_b, 1'b0), fwd_hit(mem_q, sb, dec_use_b, 1'b1));
    ex_d = SHADOW_NOP;
    if (!hold) begin
      ex_d.valid   = 1'b1;
      ex_d.we      = dec_we;
      ex_d.dst     = SH_AW'(dec_dst);
      ex_d.is_load = dec_is_load;
    end
    stall_cnt_d = stall_eff ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // ---- ID -> EX boundary: shadows advance, forward selects registered ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= SHADOW_NOP;
      mem_q       <= SHADOW_NOP;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_ctrl_a     = fwd_a_q;
  assign bus.fwd_ctrl_b     = fwd_b_q;
  assign bus.pc_write_en    = rst | ~stall_eff;
  assign bus.if_id_write_en = rst | ~stall_eff;
  assign bus.if_id_flush    = ~rst & flush;
  assign bus.id_ex_bubble   = ~rst & hold;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: an instruction-word level pipeline
// model checked every cycle, plus hand-computed expectations per scenario.
module tb_fwd_hazard_unit;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwd_hazard_if #(.CNT_W(CW)) bus ();

  fwd_hazard_unit #(.CNT_W(CW), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Model: architectural meaning of an instruction word
  function automatic int m_dst(logic [31:0] w);
    int op = int'(w[31:26]);
    int r  = -1;
    if (op == 'h00) r = int'(w[15:11]);
    else if (op == 'h23 || op == 'h08) r = int'(w[20:16]);
    if (r == 0) r = -1;
    return r;
  endfunction

  function automatic int m_src(logic [31:0] w, int k);
    int op = int'(w[31:26]);
    if (k == 0 && (op == 'h00 || op == 'h23 || op == 'h2B || op == 'h04 || op == 'h08))
      return int'(w[25:21]);
    if (k == 1 && (op == 'h00 || op == 'h2B || op == 'h04))
      return int'(w[20:16]);
    return -2;
  endfunction

  logic [31:0] m_ex = '0, m_mem = '0;
  int m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;
  localparam int CMAX = (1 << CW) - 1;

  always @(negedge clk) begin
    logic [31:0] id;
    logic br;
    int sa, sb, de, dm;
    bit lu, stall;
    id = bus.if_id_inst;
    br = bus.branch_taken;
    sa = m_src(id, 0);
    sb = m_src(id, 1);
    de = m_dst(m_ex);
    dm = m_dst(m_mem);
    lu = (m_ex[31:26] == 6'h23) && de >= 0 && (sa == de || sb == de);
    stall = lu && !br;
    if (rst) begin
      chk("m_pc_write_en", bus.pc_write_en, 1);
      chk("m_if_id_write_en", bus.if_id_write_en, 1);
      chk("m_if_id_flush", bus.if_id_flush, 0);
      chk("m_id_ex_bubble", bus.id_ex_bubble, 0);
    end else begin
      chk("m_pc_write_en", bus.pc_write_en, !stall);
      chk("m_if_id_write_en", bus.if_id_write_en, !stall);
      chk("m_if_id_flush", bus.if_id_flush, br);
      chk("m_id_ex_bubble", bus.id_ex_bubble, br || lu);
    end
    chk("m_fwd_ctrl_a", bus.fwd_ctrl_a, m_fa);
    chk("m_fwd_ctrl_b", bus.fwd_ctrl_b, m_fb);
    chk("m_stall_count", bus.stall_count, m_sc);
    chk("m_flush_count", bus.flush_count, m_fc);
    // state the coming rising edge will produce
    if (rst) begin
      m_ex = '0; m_mem = '0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (br || lu) begin
        m_fa = 0;
        m_fb = 0;
      end else begin
        m_fa = (sa == de) ? 1 : (sa == dm) ? 2 : 0;
        m_fb = (sb == de) ? 1 : (sb == dm) ? 2 : 0;
      end
      m_mem = m_ex;
      m_ex  = (br || lu) ? 32'h0 : id;
      if (br) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      else if (lu) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    end
  end

  task automatic cyc(input logic [31:0] w, input logic br, input logic r);
    @(posedge clk);
    #1;
    bus.if_id_inst   = w;
    bus.branch_taken = br;
    rst              = r;
    #1;
  endtask

  logic [31:0] NOP, ADD3, SUB534, AND673, ADDI331, OR833, LW4, ADD542, ADD012, ADD500;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    NOP     = 32'h0;
    ADD3    = rtype(1, 2, 3, 'h20);
    SUB534  = rtype(3, 4, 5, 'h22);
    AND673  = rtype(7, 3, 6, 'h24);
    ADDI331 = itype('h08, 3, 3, 1);
    OR833   = rtype(3, 3, 8, 'h25);
    LW4     = itype('h23, 1, 4, 0);
    ADD542  = rtype(4, 2, 5, 'h20);
    ADD012  = rtype(1, 2, 0, 'h20);
    ADD500  = rtype(0, 0, 5, 'h20);

    bus.if_id_inst   = NOP;
    bus.branch_taken = 1'b1;
    rst              = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_fwd_a", bus.fwd_ctrl_a, 0);
    chk("rst_fwd_b", bus.fwd_ctrl_b, 0);
    chk("rst_pc_we", bus.pc_write_en, 1);
    chk("rst_ifid_we", bus.if_id_write_en, 1);
    chk("rst_flush", bus.if_id_flush, 0);
    chk("rst_bubble", bus.id_ex_bubble, 0);
    chk("rst_stall_cnt", bus.stall_count, 0);
    chk("rst_flush_cnt", bus.flush_count, 0);

    // add $3 ; sub $5,$3,$4
    cyc(NOP, 0, 0);
    cyc(ADD3, 0, 0);
    cyc(SUB534, 0, 0);
    cyc(NOP, 0, 0);
    chk("exmem_fwd_a", bus.fwd_ctrl_a, 1);
    chk("exmem_fwd_b", bus.fwd_ctrl_b, 0);

    // add $3 ; nop ; and $6,$7,$3
    cyc(ADD3, 0, 0);
    cyc(NOP, 0, 0);
    cyc(AND673, 0, 0);
    cyc(NOP, 0, 0);
    chk("memwb_fwd_a", bus.fwd_ctrl_a, 0);
    chk("memwb_fwd_b", bus.fwd_ctrl_b, 2);

    // add $3 ; addi $3,$3,1 ; or $8,$3,$3
    cyc(ADD3, 0, 0);
    cyc(ADDI331, 0, 0);
    cyc(OR833, 0, 0);
    chk("addi_fwd_a", bus.fwd_ctrl_a, 1);
    chk("addi_fwd_b", bus.fwd_ctrl_b, 0);
    cyc(NOP, 0, 0);
    chk("prio_fwd_a", bus.fwd_ctrl_a, 1);
    chk("prio_fwd_b", bus.fwd_ctrl_b, 1);

    // lw $4 ; add $5,$4,$2 -> one stall then MEM/WB forward
    cyc(LW4, 0, 0);
    cyc(ADD542, 0, 0);
    chk("lu_pc_we", bus.pc_write_en, 0);
    chk("lu_ifid_we", bus.if_id_write_en, 0);
    chk("lu_bubble", bus.id_ex_bubble, 1);
    chk("lu_stall_cnt_before", bus.stall_count, 0);
    cyc(ADD542, 0, 0);
    chk("lu_release_pc_we", bus.pc_write_en, 1);
    chk("lu_release_bubble", bus.id_ex_bubble, 0);
    chk("lu_stall_cnt_after", bus.stall_count, 1);
    cyc(NOP, 0, 0);
    chk("lu_fwd_a", bus.fwd_ctrl_a, 2);
    chk("lu_fwd_b", bus.fwd_ctrl_b, 0);

    // taken branch on top of a load-use
    cyc(LW4, 0, 0);
    cyc(ADD542, 1, 0);
    chk("br_flush", bus.if_id_flush, 1);
    chk("br_bubble", bus.id_ex_bubble, 1);
    chk("br_pc_we", bus.pc_write_en, 1);
    chk("br_ifid_we", bus.if_id_write_en, 1);
    cyc(NOP, 0, 0);
    chk("br_flush_cnt", bus.flush_count, 1);
    chk("br_stall_cnt", bus.stall_count, 1);
    chk("br_fwd_a", bus.fwd_ctrl_a, 0);

    // $0 destination never forwards
    cyc(ADD012, 0, 0);
    cyc(ADD500, 0, 0);
    cyc(NOP, 0, 0);
    chk("r0_fwd_a", bus.fwd_ctrl_a, 0);
    chk("r0_fwd_b", bus.fwd_ctrl_b, 0);

    // drive the stall counter past all-ones
    for (int i = 0; i < 16; i++) begin
      cyc(LW4, 0, 0);
      cyc(ADD542, 0, 0);
      cyc(ADD542, 0, 0);
    end
    cyc(NOP, 0, 0);
    chk("sat_stall_cnt", bus.stall_count, CMAX);
    chk("sat_flush_cnt", bus.flush_count, 1);

    // reset mid-stream forces outputs and clears state
    cyc(LW4, 0, 0);
    cyc(ADD542, 1, 1);
    chk("mid_rst_flush", bus.if_id_flush, 0);
    chk("mid_rst_bubble", bus.id_ex_bubble, 0);
    chk("mid_rst_pc_we", bus.pc_write_en, 1);
    cyc(ADD3, 0, 0);
    chk("mid_rst_stall_cnt", bus.stall_count, 0);
    chk("mid_rst_flush_cnt", bus.flush_count, 0);
    cyc(SUB534, 0, 1);
    cyc(NOP, 0, 0);
    chk("mid_rst_fwd_a", bus.fwd_ctrl_a, 0);
    chk("mid_rst_fwd_b", bus.fwd_ctrl_b, 0);

    cyc(NOP, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
